// File: rtl/h264_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// h264_frame_ctrl_if
// Bundles the command, status and core-handshake signals of the frame
// sequencer.
//   slave  : the sequencer. It receives CPU commands and core pulses, and it
//            drives the core reset/enable, the status outputs and the IRQs.
//   master : the CPU register block and encoder core side.
// Signals:
//   start, abort            one-cycle CPU commands
//   frame_w_mb, frame_h_mb  frame size in macroblocks (sampled at start)
//   buf_thresh              packer stall threshold (sampled at start)
//   h264_buf_cnt            live packer buffer word count
//   h264_buf_clear          CPU has drained the packer buffer
//   mb_fetch, mb_done       per-macroblock pulses from fetch / packer
//   h264_reset, h264_en     core reset pulse and fetch enable
//   busy, stall             status
//   done_irq, err_irq       one-cycle interrupts
//   err_code                0 none, 1 zero dim, 2 watchdog, 3 abort
//   mb_done_cnt             macroblocks completed in the current/last frame
// ---------------------------------------------------------------------------
interface h264_frame_ctrl_if;
    logic        start;
    logic        abort;
    logic [5:0]  frame_w_mb;
    logic [5:0]  frame_h_mb;
    logic [31:0] buf_thresh;
    logic [31:0] h264_buf_cnt;
    logic        h264_buf_clear;
    logic        mb_fetch;
    logic        mb_done;
    logic        h264_reset;
    logic        h264_en;
    logic        busy;
    logic        stall;
    logic        done_irq;
    logic        err_irq;
    logic [1:0]  err_code;
    logic [11:0] mb_done_cnt;

    modport master (
        output start, abort, frame_w_mb, frame_h_mb, buf_thresh,
               h264_buf_cnt, h264_buf_clear, mb_fetch, mb_done,
        input  h264_reset, h264_en, busy, stall, done_irq, err_irq,
               err_code, mb_done_cnt
    );

    modport slave (
        input  start, abort, frame_w_mb, frame_h_mb, buf_thresh,
               h264_buf_cnt, h264_buf_clear, mb_fetch, mb_done,
        output h264_reset, h264_en, busy, stall, done_irq, err_irq,
               err_code, mb_done_cnt
    );
endinterface

// File: rtl/h264_frame_ctrl.sv
// ---------------------------------------------------------------------------
// h264_frame_ctrl
// Frame-level sequencer for the H.264 encoder core. It starts a frame with a
// core reset pulse and then enables macroblock fetch. It stalls fetch while
// the packer buffer is at or above the threshold. It counts fetched and
// completed macroblocks and finishes with done_irq. It reports a zero
// dimension, an abort or a watchdog expiry with err_irq/err_code.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  h264_frame_ctrl_if.slave (commands, core pulses, status, IRQs)
// Parameters:
//   WDOG_CYCLES  cycles in RUN/DRAIN without mb_done before a watchdog error
//   RST_CYCLES   length of the h264_reset pulse (>= 1)
// ---------------------------------------------------------------------------
module h264_frame_ctrl #(
    parameter int unsigned WDOG_CYCLES = 65535,
    parameter int unsigned RST_CYCLES  = 2
) (
    input  logic             clk,
    input  logic             rst,
    h264_frame_ctrl_if.slave bus
);
    localparam int WDW = $clog2(WDOG_CYCLES + 1);
    localparam int RCW = $clog2(RST_CYCLES + 1);
    localparam logic [WDW-1:0] WDOG_LAST = WDW'(WDOG_CYCLES - 1);
    localparam logic [RCW-1:0] RST_LOAD  = RCW'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_RUN, S_STALL, S_DRAIN, S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [11:0]    total_q, fetch_q, done_q, fetch_d, done_d;
    logic [31:0]    thresh_q;
    logic           ge_q;
    logic [WDW-1:0] wdog_q;
    logic [RCW-1:0] rcnt_q;
    logic           hrst_q, en_q, busy_q, stall_q, done_irq_q, err_irq_q;
    logic [1:0]     err_code_q;

    logic idle, active, dims_ok, start_ok, start_bad, abort_hit;
    logic wd_zone, wdog_exp, err_fire, rst_last;

    assign idle      = (state_q == S_IDLE);
    assign active    = (state_q == S_INIT) || (state_q == S_RUN) ||
                       (state_q == S_STALL) || (state_q == S_DRAIN);
    assign dims_ok   = (bus.frame_w_mb != 6'd0) && (bus.frame_h_mb != 6'd0);
    assign start_ok  = idle && bus.start && dims_ok;
    assign start_bad = idle && bus.start && !dims_ok;
    assign abort_hit = !idle && bus.abort;
    assign wd_zone   = (state_q == S_RUN) || (state_q == S_DRAIN);
    // An mb_done in the expiry cycle rescues the frame.
    assign wdog_exp  = wd_zone && !bus.mb_done && (wdog_q == WDOG_LAST);
    assign err_fire  = abort_hit || wdog_exp;
    // Last cycle of the start-of-frame reset pulse.
    assign rst_last  = hrst_q && (rcnt_q == '0);

    // Counters saturate at total. The "_d" values include this cycle's
    // pulse, so the RUN->DRAIN and DRAIN->DONE checks see it.
    assign fetch_d = fetch_q + 12'(active && bus.mb_fetch && (fetch_q != total_q));
    assign done_d  = done_q  + 12'(active && bus.mb_done  && (done_q  != total_q));

    always_comb begin
        state_d = state_q;
        if (abort_hit) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start_ok) state_d = S_INIT;
                S_INIT:  if (rst_last) state_d = S_RUN;
                S_RUN: begin
                    if (wdog_exp)                 state_d = S_IDLE;
                    else if (fetch_d == total_q)  state_d = S_DRAIN;
                    else if (ge_q)                state_d = S_STALL;
                end
                S_STALL: if (bus.h264_buf_clear || !ge_q) state_d = S_RUN;
                S_DRAIN: begin
                    if (wdog_exp)                 state_d = S_IDLE;
                    else if (done_d == total_q)   state_d = S_DONE;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            total_q    <= '0;
            fetch_q    <= '0;
            done_q     <= '0;
            thresh_q   <= '0;
            ge_q       <= 1'b0;
            wdog_q     <= '0;
            rcnt_q     <= '0;
            hrst_q     <= 1'b0;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            stall_q    <= 1'b0;
            done_irq_q <= 1'b0;
            err_irq_q  <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            busy_q     <= (state_d != S_IDLE);
            en_q       <= (state_d == S_RUN);
            stall_q    <= (state_d == S_STALL);
            done_irq_q <= (state_d == S_DONE);
            err_irq_q  <= start_bad || err_fire;
            // Registered compare: this adds one cycle to the stall
            // response.
            ge_q       <= (bus.h264_buf_cnt >= thresh_q);

            if (start_ok) begin
                total_q    <= {6'd0, bus.frame_w_mb} * {6'd0, bus.frame_h_mb};
                thresh_q   <= bus.buf_thresh;
                fetch_q    <= '0;
                done_q     <= '0;
                err_code_q <= 2'd0;
            end else begin
                fetch_q <= fetch_d;
                done_q  <= done_d;
                if (start_bad)      err_code_q <= 2'd1;
                else if (abort_hit) err_code_q <= 2'd3;
                else if (wdog_exp)  err_code_q <= 2'd2;
            end

            // Reset pulse runs on its own counter so it can outlive busy
            // after an error.
            if (start_ok || err_fire) begin
                hrst_q <= 1'b1;
                rcnt_q <= RST_LOAD;
            end else if (rcnt_q != '0) begin
                rcnt_q <= rcnt_q - RCW'(1);
            end else begin
                hrst_q <= 1'b0;
            end

            // The watchdog runs only in RUN/DRAIN. Leaving them (STALL,
            // INIT) clears it, so re-entry to RUN starts from zero.
            if (!wd_zone || bus.mb_done)  wdog_q <= '0;
            else if (wdog_q != WDOG_LAST) wdog_q <= wdog_q + WDW'(1);
        end
    end

    assign bus.h264_reset  = hrst_q;
    assign bus.h264_en     = en_q;
    assign bus.busy        = busy_q;
    assign bus.stall       = stall_q;
    assign bus.done_irq    = done_irq_q;
    assign bus.err_irq     = err_irq_q;
    assign bus.err_code    = err_code_q;
    assign bus.mb_done_cnt = done_q;
endmodule

// File: tb/tb_h264_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_h264_frame_ctrl
// Self-checking bench for h264_frame_ctrl. It runs directed frames for
// start/reset timing, a zero dimension, stall/clear, watchdog, abort,
// mid-frame rst and a 63x63 saturating frame. It then runs randomized frames
// whose expected outcome (total = w*h, done latency, enable drop after the
// last fetch, a single done_irq) is computed from plain arithmetic.
// ---------------------------------------------------------------------------
module tb_h264_frame_ctrl;
    localparam int WDOG = 16;
    localparam int RSTC = 2;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    h264_frame_ctrl_if bus ();

    h264_frame_ctrl #(.WDOG_CYCLES(WDOG), .RST_CYCLES(RSTC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.start          = 1'b0;
        bus.abort          = 1'b0;
        bus.frame_w_mb     = 6'd0;
        bus.frame_h_mb     = 6'd0;
        bus.buf_thresh     = 32'd0;
        bus.h264_buf_cnt   = 32'd0;
        bus.h264_buf_clear = 1'b0;
        bus.mb_fetch       = 1'b0;
        bus.mb_done        = 1'b0;
    endtask

    task automatic do_start(input int w, input int h, input int thr);
        bus.frame_w_mb = 6'(w);
        bus.frame_h_mb = 6'(h);
        bus.buf_thresh = 32'(thr);
        bus.start      = 1'b1;
        step();
        bus.start      = 1'b0;
    endtask

    task automatic wait_en(input string tag);
        for (int k = 0; k < 20 && !bus.h264_en; k++) step();
        chk(tag, bus.h264_en, 1);
    endtask

    task automatic rand_frame();
        int w, h, thr, tot, fi, di, gf, gd, last_d, irqs, errs;
        bit fin;
        w   = $urandom_range(0, 5);
        h   = $urandom_range(0, 5);
        thr = $urandom_range(1, 1000);
        tot = w * h;
        bus.h264_buf_cnt = 32'd0;
        do_start(w, h, thr);
        if (tot == 0) begin
            chk("r_zero_irq", bus.err_irq, 1);
            chk("r_zero_code", bus.err_code, 1);
            chk("r_zero_busy", bus.busy, 0);
            step();
            return;
        end
        chk("r_code_clr", bus.err_code, 0);
        chk("r_busy", bus.busy, 1);
        fi = 0; di = 0; gf = 0; gd = 0; irqs = 0; errs = 0; fin = 0; last_d = -10;
        for (int k = 0; k < 3000 && !fin; k++) begin
            if (bus.done_irq) begin
                irqs++;
                chk("r_done_lat", cyc - last_d, 1);
                chk("r_cnt", bus.mb_done_cnt, tot);
            end else if (irqs > 0) begin
                chk("r_busy_end", bus.busy, 0);
                fin = 1;
            end
            if (bus.err_irq) errs++;
            if (bus.stall) chk("r_stall_en", bus.h264_en, 0);
            bus.mb_fetch       = bus.h264_en && fi < tot && ($urandom_range(0, 1) == 1 || gf >= 4);
            bus.mb_done        = di < fi && ($urandom_range(0, 1) == 1 || gd >= 5);
            bus.h264_buf_cnt   = ($urandom_range(0, 9) == 0) ? 32'(thr) : 32'd0;
            bus.h264_buf_clear = bus.stall && $urandom_range(0, 2) == 0;
            gf = bus.mb_fetch ? 0 : gf + 1;
            gd = bus.mb_done  ? 0 : gd + 1;
            if (bus.mb_fetch) fi++;
            if (bus.mb_done) begin
                di++;
                if (di == tot) last_d = cyc;
            end
            step();
            if (bus.mb_fetch && fi == tot) chk("r_en_drop", bus.h264_en, 0);
        end
        clear_in();
        chk("r_fin", 32'(fin), 1);
        chk("r_irqs", irqs, 1);
        chk("r_errs", errs, 0);
        step();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r, nf;
        rst = 1'b1;
        clear_in();
        repeat (3) step();
        chk("rst_busy", bus.busy, 0);
        chk("rst_en", bus.h264_en, 0);
        chk("rst_hrst", bus.h264_reset, 0);
        chk("rst_stall", bus.stall, 0);
        chk("rst_done", bus.done_irq, 0);
        chk("rst_err", bus.err_irq, 0);
        chk("rst_code", bus.err_code, 0);
        chk("rst_cnt", bus.mb_done_cnt, 0);
        rst = 1'b0;
        step();

        // 2x2 frame, no stall.
        bus.h264_buf_cnt = 32'd0;
        do_start(2, 2, 1000);
        chk("t1_hrst1", bus.h264_reset, 1);
        chk("t1_busy", bus.busy, 1);
        chk("t1_en0", bus.h264_en, 0);
        step();
        chk("t1_hrst2", bus.h264_reset, 1);
        chk("t1_en1", bus.h264_en, 0);
        step();
        chk("t1_hrst_end", bus.h264_reset, 0);
        chk("t1_en_on", bus.h264_en, 1);
        for (int i = 0; i < 4; i++) begin
            bus.mb_fetch = 1'b1;
            step();
            chk("t1_en_fetch", bus.h264_en, 32'(i < 3));
        end
        bus.mb_fetch = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.mb_done = 1'b1;
            step();
            chk("t1_done_irq", bus.done_irq, 32'(i == 3));
        end
        bus.mb_done = 1'b0;
        chk("t1_cnt", bus.mb_done_cnt, 4);
        chk("t1_busy_done", bus.busy, 1);
        step();
        chk("t1_irq_off", bus.done_irq, 0);
        chk("t1_idle", bus.busy, 0);

        // Zero width.
        do_start(0, 3, 10);
        chk("z_irq", bus.err_irq, 1);
        chk("z_code", bus.err_code, 1);
        chk("z_busy", bus.busy, 0);
        step();
        chk("z_irq_off", bus.err_irq, 0);
        chk("z_code_hold", bus.err_code, 1);
        chk("z_busy2", bus.busy, 0);

        // 4x1 frame, stall at threshold 8, release with buf_clear.
        do_start(4, 1, 8);
        chk("s_code_clr", bus.err_code, 0);
        wait_en("s_en");
        bus.mb_fetch = 1'b1; step();
        bus.mb_fetch = 1'b1; step();
        bus.mb_fetch = 1'b0;
        bus.h264_buf_cnt = 32'd8;
        step();
        chk("s_en_t1", bus.h264_en, 1);
        chk("s_stall_t1", bus.stall, 0);
        step();
        chk("s_en_t2", bus.h264_en, 0);
        chk("s_stall_t2", bus.stall, 1);
        bus.mb_done = 1'b1; step(); step();
        bus.mb_done = 1'b0;
        repeat (20) step();
        chk("s_still_stall", bus.stall, 1);
        chk("s_cnt_stall", bus.mb_done_cnt, 2);
        bus.h264_buf_clear = 1'b1;
        bus.h264_buf_cnt   = 32'd0;
        step();
        bus.h264_buf_clear = 1'b0;
        chk("s_en_clear", bus.h264_en, 1);
        chk("s_stall_clear", bus.stall, 0);
        bus.mb_fetch = 1'b1; step(); step();
        bus.mb_fetch = 1'b0;
        chk("s_en_drain", bus.h264_en, 0);
        for (int i = 0; i < 2; i++) begin
            bus.mb_done = 1'b1;
            step();
            chk("s_done_irq", bus.done_irq, 32'(i == 1));
        end
        bus.mb_done = 1'b0;
        chk("s_cnt", bus.mb_done_cnt, 4);
        step();

        // Watchdog in DRAIN.
        do_start(1, 1, 1000);
        wait_en("w_en");
        r = cyc;
        bus.mb_fetch = 1'b1; step();
        bus.mb_fetch = 1'b0;
        chk("w_drain_en", bus.h264_en, 0);
        for (int k = 0; k < 40 && !bus.err_irq; k++) step();
        chk("w_irq", bus.err_irq, 1);
        chk("w_lat", cyc - r, WDOG);
        chk("w_code", bus.err_code, 2);
        chk("w_busy", bus.busy, 0);
        chk("w_hrst1", bus.h264_reset, 1);
        step();
        chk("w_hrst2", bus.h264_reset, 1);
        chk("w_irq_off", bus.err_irq, 0);
        step();
        chk("w_hrst_end", bus.h264_reset, 0);

        // Abort during STALL, then a new start clears err_code.
        do_start(2, 2, 5);
        wait_en("a_en");
        bus.mb_fetch = 1'b1; step();
        bus.mb_fetch = 1'b0;
        bus.h264_buf_cnt = 32'd5;
        for (int k = 0; k < 10 && !bus.stall; k++) step();
        chk("a_stall", bus.stall, 1);
        bus.abort = 1'b1; step();
        bus.abort = 1'b0;
        chk("a_irq", bus.err_irq, 1);
        chk("a_code", bus.err_code, 3);
        chk("a_busy", bus.busy, 0);
        chk("a_stall_off", bus.stall, 0);
        chk("a_hrst1", bus.h264_reset, 1);
        step();
        chk("a_hrst2", bus.h264_reset, 1);
        step();
        chk("a_hrst_end", bus.h264_reset, 0);
        chk("a_code_hold", bus.err_code, 3);
        bus.h264_buf_cnt = 32'd0;
        do_start(1, 1, 1000);
        chk("a_code_clr", bus.err_code, 0);
        wait_en("a_en2");
        bus.mb_fetch = 1'b1; step();
        bus.mb_fetch = 1'b0;
        bus.mb_done  = 1'b1; step();
        bus.mb_done  = 1'b0;
        chk("a_done2", bus.done_irq, 1);
        step();

        // rst in RUN with three macroblocks completed.
        do_start(2, 2, 1000);
        wait_en("x_en");
        for (int i = 0; i < 3; i++) begin
            bus.mb_fetch = 1'b1; bus.mb_done = 1'b1; step();
        end
        bus.mb_fetch = 1'b0; bus.mb_done = 1'b0;
        chk("x_cnt3", bus.mb_done_cnt, 3);
        chk("x_en_run", bus.h264_en, 1);
        rst = 1'b1; step();
        chk("x_busy", bus.busy, 0);
        chk("x_en", bus.h264_en, 0);
        chk("x_hrst", bus.h264_reset, 0);
        chk("x_cnt", bus.mb_done_cnt, 0);
        chk("x_code", bus.err_code, 0);
        rst = 1'b0; step();
        chk("x_hrst2", bus.h264_reset, 0);

        // 63x63: mb_done every cycle, fetch every other cycle.
        do_start(63, 63, 1000);
        wait_en("b_en");
        nf = 0;
        for (int k = 0; k < 12000 && !bus.done_irq; k++) begin
            bus.mb_fetch = bus.h264_en && (k % 2 == 0);
            bus.mb_done  = 1'b1;
            if (bus.mb_fetch) nf++;
            step();
            if (k == 4000) begin
                chk("b_sat", bus.mb_done_cnt, 3969);
                chk("b_en_mid", bus.h264_en, 1);
            end
        end
        bus.mb_fetch = 1'b0; bus.mb_done = 1'b0;
        chk("b_irq", bus.done_irq, 1);
        chk("b_cnt", bus.mb_done_cnt, 3969);
        chk("b_fetches", nf, 3969);
        step();

        for (int n = 0; n < 25; n++) rand_frame();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
